// File: rtl/slave_port.sv
// Serial-bus slave port: deserialises address/mode/write data, drives a
// synchronous memory interface and serialises read data back LSB first.
module slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      MEMWR,
      MEMRD,
      RWAIT,
      RDATA
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    mode_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   wdata_reg;
   logic [DATA_WIDTH-1:0]   rdata_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (mvalid) state_next = ADDR;
         ADDR:    if (mvalid && cnt_reg == ADDR_LAST) state_next = mode_reg ? WDATA : MEMRD;
         WDATA:   if (mvalid && cnt_reg == DATA_LAST) state_next = MEMWR;
         MEMWR:   state_next = IDLE;
         MEMRD:   state_next = RWAIT;
         RWAIT:   if (mem_rvalid) state_next = RDATA;
         RDATA:   if (cnt_reg == DATA_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Both address and data arrive LSB first, so shifting in from the top
   // leaves the first bit in position 0 once the field is complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         mode_reg  <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mvalid) begin
                  addr_reg <= {swdata, addr_reg[ADDR_WIDTH-1:1]};
                  mode_reg <= smode;
                  cnt_reg  <= CNT_ONE;
               end
            end
            ADDR: begin
               if (mvalid) begin
                  addr_reg <= {swdata, addr_reg[ADDR_WIDTH-1:1]};
                  cnt_reg  <= (cnt_reg == ADDR_LAST) ? '0 : cnt_reg + CNT_ONE;
               end
            end
            WDATA: begin
               if (mvalid) begin
                  wdata_reg <= {swdata, wdata_reg[DATA_WIDTH-1:1]};
                  cnt_reg   <= (cnt_reg == DATA_LAST) ? '0 : cnt_reg + CNT_ONE;
               end
            end
            RWAIT: begin
               if (mem_rvalid) begin
                  rdata_reg <= mem_rdata;
                  cnt_reg   <= '0;
               end
            end
            RDATA: begin
               rdata_reg <= {1'b0, rdata_reg[DATA_WIDTH-1:1]};
               cnt_reg   <= (cnt_reg == DATA_LAST) ? '0 : cnt_reg + CNT_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      sready  = (state_reg == IDLE);
      svalid  = (state_reg == RDATA);
      srdata  = (state_reg == RDATA) & rdata_reg[0];
      mem_wen = (state_reg == MEMWR);
      mem_ren = (state_reg == MEMRD);
   end

   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed frames, a timeline model built from the
// frame-level timing rules, and a per-cycle compare against it.
module tb_slave_port;

   localparam int A    = 12;
   localparam int D    = 8;
   localparam int NCYC = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          swdata, smode, mvalid;
   logic          srdata, svalid, sready;
   logic [A-1:0]  mem_addr;
   logic [D-1:0]  mem_wdata;
   logic          mem_wen, mem_ren;
   logic [D-1:0]  mem_rdata;
   logic          mem_rvalid;

   slave_port #(.ADDR_WIDTH(A), .DATA_WIDTH(D)) dut (
      .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(mvalid),
      .srdata(srdata), .svalid(svalid), .sready(sready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int errors = 0;
   int checks = 0;
   bit checking = 0;

   // Expected timeline, indexed by cycle number.
   bit         exp_sready [NCYC];
   bit         exp_wen    [NCYC];
   bit         exp_ren    [NCYC];
   bit         exp_sv     [NCYC];
   bit         exp_sd     [NCYC];
   logic [A-1:0] exp_addr [NCYC];
   logic [D-1:0] exp_wd   [NCYC];
   logic [D-1:0] exp_mem  [1 << A];

   // Memory behind the port, with programmable read latency.
   logic [D-1:0] bram [1 << A];
   int           lat = 1;
   int           rv_cyc = -1;
   logic [A-1:0] rv_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Fill the expected timeline for one frame from the frame timing rules.
   task automatic plan(input bit mode, input logic [A-1:0] a, input logic [D-1:0] d,
                       input int t0, input int ga_n, input int gd_n, input int l);
      int a_end, last, rv;
      a_end = t0 + A - 1 + ga_n;
      if (mode) begin
         last = a_end + D + gd_n;
         for (int c = t0 + 1; c <= last + 1; c++) exp_sready[c] = 1'b0;
         exp_wen[last + 1]  = 1'b1;
         exp_addr[last + 1] = a;
         exp_wd[last + 1]   = d;
         exp_mem[a]         = d;
      end else begin
         rv = a_end + 1 + l;
         for (int c = t0 + 1; c <= rv + D; c++) exp_sready[c] = 1'b0;
         exp_ren[a_end + 1]  = 1'b1;
         exp_addr[a_end + 1] = a;
         for (int i = 0; i < D; i++) begin
            exp_sv[rv + 1 + i] = 1'b1;
            exp_sd[rv + 1 + i] = exp_mem[a][i];
         end
      end
   endtask

   task automatic gap_cycles(input int n);
      repeat (n) begin
         next_cycle();
         mvalid = 1'b0;
         swdata = 1'($urandom);
         smode  = 1'($urandom);
      end
   endtask

   task automatic frame(input bit mode, input logic [A-1:0] a, input logic [D-1:0] d,
                        input int ga_i, input int ga_n, input int gd_i, input int gd_n,
                        input int l, input bit noise, output int t0);
      int post;
      lat = l;
      t0  = 0;
      for (int i = 0; i < A; i++) begin
         next_cycle();
         if (i == 0) begin
            t0 = cyc;
            plan(mode, a, d, t0, (ga_i >= 0) ? ga_n : 0, (gd_i >= 0) ? gd_n : 0, l);
         end
         mvalid = 1'b1;
         swdata = a[i];
         smode  = (i == 0) ? mode : ~mode;
         if (i == ga_i) gap_cycles(ga_n);
      end
      if (mode) begin
         for (int i = 0; i < D; i++) begin
            next_cycle();
            mvalid = 1'b1;
            swdata = d[i];
            smode  = 1'($urandom);
            if (i == gd_i) gap_cycles(gd_n);
         end
      end
      post = mode ? 1 : 1 + l + D;
      repeat (post) begin
         next_cycle();
         mvalid = noise ? 1'($urandom) : 1'b0;
         swdata = 1'($urandom);
         smode  = 1'($urandom);
      end
      $display("frame %s addr=%03h data=%02h t0=%0d lat=%0d", mode ? "WR" : "RD", a, d, t0, l);
   endtask

   // Observed event times, used for the hand-computed literal checks.
   int wen_cyc, ren_cyc, sv_first, sv_last, rdy_cyc, wen_cnt, sv_cnt;
   logic [D-1:0] rbits;
   bit prev_sready = 1'b1;

   task automatic clear_mon();
      wen_cyc = -1; ren_cyc = -1; sv_first = -1; sv_last = -1; rdy_cyc = -1;
      wen_cnt = 0;  sv_cnt = 0;   rbits = '0;
   endtask

   always @(negedge clk) begin
      if (mem_wen) begin
         wen_cyc = cyc;
         wen_cnt++;
         bram[mem_addr] = mem_wdata;
      end
      if (mem_ren) begin
         ren_cyc = cyc;
         rv_cyc  = cyc + lat;
         rv_addr = mem_addr;
      end
      if (svalid) begin
         if (sv_first < 0) sv_first = cyc;
         sv_last = cyc;
         rbits   = {srdata, rbits[D-1:1]};
         sv_cnt++;
      end
      if (sready && !prev_sready) rdy_cyc = cyc;
      prev_sready = sready;
   end

   always begin
      @(posedge clk);
      #1;
      mem_rvalid = (cyc == rv_cyc);
      mem_rdata  = (cyc == rv_cyc) ? bram[rv_addr] : D'($urandom);
   end

   always @(negedge clk) begin
      if (checking && cyc < NCYC) begin
         chk("sready",  {31'd0, sready},  {31'd0, exp_sready[cyc]});
         chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen[cyc]});
         chk("mem_ren", {31'd0, mem_ren}, {31'd0, exp_ren[cyc]});
         chk("svalid",  {31'd0, svalid},  {31'd0, exp_sv[cyc]});
         if (exp_sv[cyc]) chk("srdata", {31'd0, srdata}, {31'd0, exp_sd[cyc]});
         if (exp_wen[cyc]) begin
            chk("wr_addr",  32'(mem_addr),  32'(exp_addr[cyc]));
            chk("wr_wdata", 32'(mem_wdata), 32'(exp_wd[cyc]));
         end
         if (exp_ren[cyc]) chk("rd_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      end
   end

   int t0;

   initial begin
      for (int c = 0; c < NCYC; c++) begin
         exp_sready[c] = 1'b1;
         exp_wen[c] = 1'b0; exp_ren[c] = 1'b0; exp_sv[c] = 1'b0; exp_sd[c] = 1'b0;
         exp_addr[c] = '0; exp_wd[c] = '0;
      end
      for (int i = 0; i < (1 << A); i++) begin
         exp_mem[i] = '0;
         bram[i]    = '0;
      end
      rst = 1'b1; mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      clear_mon();
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sready", {31'd0, sready},  32'd1);
      chk("rst_svalid", {31'd0, svalid},  32'd0);
      chk("rst_srdata", {31'd0, srdata},  32'd0);
      chk("rst_wen",    {31'd0, mem_wen}, 32'd0);
      chk("rst_ren",    {31'd0, mem_ren}, 32'd0);
      chk("rst_addr",   32'(mem_addr),    32'd0);
      chk("rst_wdata",  32'(mem_wdata),   32'd0);
      checking = 1'b1;

      // Write 0xA5 to 0x123, contiguous.
      clear_mon();
      frame(1'b1, 12'h123, 8'hA5, -1, 0, -1, 0, 1, 1'b0, t0);
      gap_cycles(2);
      chk("t1_wen_time", 32'(wen_cyc), 32'(t0 + 20));
      chk("t1_rdy_time", 32'(rdy_cyc), 32'(t0 + 21));
      chk("t1_wen_cnt",  32'(wen_cnt), 32'd1);

      // Read 0x123 with one-cycle memory latency.
      clear_mon();
      frame(1'b0, 12'h123, 8'h00, -1, 0, -1, 0, 1, 1'b0, t0);
      gap_cycles(2);
      chk("t2_ren_time",  32'(ren_cyc),  32'(t0 + 12));
      chk("t2_sv_first",  32'(sv_first), 32'(t0 + 14));
      chk("t2_sv_last",   32'(sv_last),  32'(t0 + 21));
      chk("t2_rdata",     32'(rbits),    32'h0000_00A5);
      chk("t2_rdy_time",  32'(rdy_cyc),  32'(t0 + 22));
      chk("t2_sv_cnt",    32'(sv_cnt),   32'd8);

      // Write 0x3C to 0xFFF with mvalid gaps inside address and data.
      clear_mon();
      frame(1'b1, 12'hFFF, 8'h3C, 5, 3, 2, 2, 1, 1'b0, t0);
      gap_cycles(2);
      chk("t3_wen_time", 32'(wen_cyc), 32'(t0 + 25));

      // Abort a write after 15 bits with a one-cycle reset.
      clear_mon();
      next_cycle();
      t0 = cyc;
      for (int c = t0 + 1; c <= t0 + 15; c++) exp_sready[c] = 1'b0;
      for (int i = 0; i < A + 3; i++) begin
         if (i > 0) next_cycle();
         mvalid = 1'b1;
         swdata = 1'($urandom);
         smode  = (i == 0) ? 1'b1 : 1'b0;
      end
      next_cycle();
      rst = 1'b1; mvalid = 1'b0;
      next_cycle();
      rst = 1'b0;
      $display("frame ABORT t0=%0d reset at cycle %0d", t0, t0 + 15);
      @(negedge clk);
      chk("t4_rdy_after_rst", {31'd0, sready}, 32'd1);
      chk("t4_no_wen",        32'(wen_cnt),    32'd0);
      frame(1'b1, 12'h000, 8'h01, -1, 0, -1, 0, 1, 1'b0, t0);
      gap_cycles(2);
      chk("t4_wen_after", 32'(wen_cnt), 32'd1);

      // Read 0xFFF, memory answers four cycles after mem_ren, bus noise.
      clear_mon();
      frame(1'b0, 12'hFFF, 8'h00, -1, 0, -1, 0, 4, 1'b1, t0);
      gap_cycles(2);
      chk("t5_rdata",    32'(rbits),   32'h0000_003C);
      chk("t5_rdy_time", 32'(rdy_cyc), 32'(t0 + A + D + 2 + 3));

      // Back-to-back write then read of the same location.
      clear_mon();
      frame(1'b1, 12'h2C7, 8'h5A, -1, 0, -1, 0, 2, 1'b1, t0);
      frame(1'b0, 12'h2C7, 8'h00, -1, 0, -1, 0, 2, 1'b0, t0);
      gap_cycles(2);
      chk("t6_rdata", 32'(rbits), 32'h0000_005A);
      chk("t6_wen_cnt", 32'(wen_cnt), 32'd1);

      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
